pool_stream: RTL

POOL_STREAM -- requirements
Module: pool_stream

---
 rtl/pool_stream_if.sv | 30 +++
 rtl/pool_stream.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pool_stream_if.sv
// Pixel-in / pooled-result-out handshake bundle
// shared by pool_stream and its stimulus side.
interface pool_stream_if #(
  parameter int input_channels       = 5,
  parameter int datatype_size        = 8,
  parameter int output_datatype_size = 8
);
  logic i_start;
  logic i_mode;
  logic i_valid;
  logic [input_channels-1:0][datatype_size-1:0] i_data;
  logic o_ready;
  logic i_next_busy;
  logic o_valid;
  logic o_last;
  logic [input_channels-1:0]
        [output_datatype_size-1:0] o_func_data;

  modport master (
    output i_start, i_mode, i_valid, i_data,
    output i_next_busy,
    input  o_ready, o_valid, o_last, o_func_data
  );

  modport slave (
    input  i_start, i_mode, i_valid, i_data,
    input  i_next_busy,
    output o_ready, o_valid, o_last, o_func_data
  );
endinterface

// File: rtl/pool_stream.sv
// Streaming NxN stride-N max/average pooling over a
// raster pixel stream, one pixel per cycle, C channels.
module pool_stream #(
  parameter int input_channels       = 5,
  parameter int img_width            = 28,
  parameter int img_height           = 28,
  parameter int kernel_dim           = 2,
  parameter int datatype_size        = 8,
  parameter int output_datatype_size = 8
) (
  input logic         clk,
  input logic         rst,
  pool_stream_if.slave bus
);
  localparam int C   = input_channels;
  localparam int W   = img_width;
  localparam int H   = img_height;
  localparam int N   = kernel_dim;
  localparam int DW  = datatype_size;
  localparam int ODW = output_datatype_size;
  localparam int LG  = $clog2(N);
  localparam int BW  = DW + 2 * LG;
  localparam int NE  = W / N;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;
  localparam int IW  = (NE > 1) ? $clog2(NE) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic        r_mode;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic        r_valid;
  logic        r_last;
  logic [C-1:0][ODW-1:0] r_data;
  logic [BW-1:0] r_buf [C][NE];

  logic          w_ready;
  logic          w_acc;
  logic          w_out_acc;
  logic          w_col_end;
  logic          w_flast;
  logic          w_first;
  logic          w_wlast;
  logic [IW-1:0] w_idx;
  logic [BW-1:0] w_px   [C];
  logic [BW-1:0] w_comb [C];
  logic [DW-1:0] w_res  [C];

  assign w_ready   = (r_state == RUN) &&
                     !(r_valid && bus.i_next_busy);
  assign w_acc     = w_ready && bus.i_valid &&
                     !bus.i_start;
  assign w_out_acc = r_valid && !bus.i_next_busy;
  assign w_col_end = (r_col == CW'(W - 1));
  assign w_flast   = w_col_end &&
                     (r_row == RW'(H - 1));
  assign w_first   = (int'(r_col) % N == 0) &&
                     (int'(r_row) % N == 0);
  assign w_wlast   = (int'(r_col) % N == N - 1) &&
                     (int'(r_row) % N == N - 1);
  assign w_idx     = IW'(int'(r_col) / N);

  assign bus.o_ready     = w_ready;
  assign bus.o_valid     = r_valid;
  assign bus.o_last      = r_last;
  assign bus.o_func_data = r_data;

  always_comb begin
    for (int c = 0; c < C; c++) begin
      w_px[c]   = BW'(bus.i_data[c]);
      w_comb[c] = '0;
      w_res[c]  = '0;
      if (w_first)
        w_comb[c] = w_px[c];
      else if (r_mode)
        w_comb[c] = r_buf[c][w_idx] + w_px[c];
      else if (w_px[c] > r_buf[c][w_idx])
        w_comb[c] = w_px[c];
      else
        w_comb[c] = r_buf[c][w_idx];
      // window sum of N*N pixels divided by N^2
      if (r_mode)
        w_res[c] = DW'(w_comb[c] >> (2 * LG));
      else
        w_res[c] = DW'(w_comb[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && !w_wlast) begin
      for (int c = 0; c < C; c++)
        r_buf[c][w_idx] <= w_comb[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (bus.i_start) begin
      r_state <= RUN;
      r_mode  <= bus.i_mode;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_out_acc) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        if (r_last)
          r_state <= IDLE;
      end
      if (w_acc) begin
        r_col <= w_col_end ? '0 : r_col + 1'b1;
        if (w_col_end)
          r_row <= w_flast ? '0 : r_row + 1'b1;
        if (w_wlast) begin
          r_valid <= 1'b1;
          r_last  <= w_flast;
          for (int c = 0; c < C; c++)
            r_data[c] <= ODW'(w_res[c]);
        end
        if (w_flast)
          r_state <= DRAIN;
      end
    end
  end
endmodule
